// File: rtl/bs_addsub_inverse_pkg.sv
// Shared types and helpers for the bit-serial add/sub inverse unit.
package addsub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Forward operation that produced R; the unit applies the opposite one.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int clog2(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/bs_addsub_inverse_fa_fs.sv
// 1-bit full adder (u=0) / full subtractor a-b-cin (u=1).
module fa_fs (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic u,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = u ? ((~a & b) | (~(a ^ b) & cin))
                  : ((a & b) | ((a ^ b) & cin));

endmodule

// File: rtl/bs_addsub_inverse.sv
// Bit-serial recovery of A from R and B, one bit per clock, LSB first.
// Optional macro ADDSUB_OVF_EN adds the signed overflow flag on ovf.
module bs_addsub_inverse
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a_out,
  output logic             flag,
  output logic             ovf
);

  localparam int CW = clog2(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] r_sh, b_sh, res_sh;
  logic             mode_q, cb;
  logic [CW-1:0]    cnt;
  logic             s, cout, last, sub_op;

  // Forward add means we must subtract to undo it.
  assign sub_op = (mode_q == MODE_ADD);
  assign last   = (cnt == CW'(WIDTH - 1));

  fa_fs u_cell (
    .a   (r_sh[0]),
    .b   (b_sh[0]),
    .cin (cb),
    .u   (sub_op),
    .s   (s),
    .cout(cout)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      r_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      mode_q <= 1'b0;
      cb     <= 1'b0;
      cnt    <= '0;
      a_out  <= '0;
      flag   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          r_sh   <= r;
          b_sh   <= b;
          mode_q <= mode;
          cb     <= 1'b0;
          cnt    <= '0;
        end
        RUN: begin
          r_sh   <= r_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {s, res_sh[WIDTH-1:1]};
          cb     <= cout;
          cnt    <= cnt + CW'(1);
          if (last) begin
            a_out <= {s, res_sh[WIDTH-1:1]};
            flag  <= cout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADDSUB_OVF_EN
  logic ovf_q;

  // On the last bit cb is the carry/borrow into the MSB, cout the one out of it.
  always_ff @(posedge clk) begin
    if (rst)                        ovf_q <= 1'b0;
    else if (state == IDLE && start) ovf_q <= 1'b0;
    else if (state == RUN && last)   ovf_q <= cb ^ cout;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
